apb_master_bridge: RTL

- Converts a simple valid/ready command stream into APB4 transfers, acting as the requester end of the APB bus, and returns each transfer's result on a valid/ready response stream.
- Sits between RAL/test-sequencer or CPU-side logic and the APB register slave.
- Drives PADDR/PSELx/PENABLE/PSTRB/PWRITE/PWDATA; samples PRDATA/PREADY/PSLVERR.
- One outstanding transfer at a time.

---
 rtl/apb_master_pkg.sv | 27 ++
 rtl/apb_timeout_cnt.sv | 37 +++
 rtl/apb_master_bridge.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/apb_master_pkg.sv
// Shared types and defaults for the APB requester bridge and the code that drives it.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef struct packed {
    logic                    write;
    logic [ADDR_W_DEF-1:0]   addr;
    logic [DATA_W_DEF-1:0]   wdata;
    logic [DATA_W_DEF/8-1:0] strb;
  } apb_cmd_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] rdata;
    logic                  slverr;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS cycles that end without PREADY; limit fires on the cycle that would be the
// TIMEOUT_CYCLES-th such cycle, so a PREADY arriving in that same cycle still wins.
module apb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic limit
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign limit = enable && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command stream to APB4 requester, one transfer in flight, registered outputs.
// Optional ACCESS-phase abort is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int  ADDR_W         = ADDR_W_DEF,
  parameter int  DATA_W         = DATA_W_DEF,
  parameter int  TIMEOUT_CYCLES = 256,
  localparam int STRB_W         = DATA_W / 8
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_strb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSELx,
  output logic              PENABLE,
  output logic [STRB_W-1:0] PSTRB,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  if ((DATA_W % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("apb_master_bridge: DATA_W must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
  end

  apb_state_e        state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_slverr_q, rsp_slverr_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              to_limit;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .clear (state_q == SETUP),
    .enable((state_q == ACCESS) && !PREADY),
    .limit (to_limit)
  );
`else
  assign to_limit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    paddr_d       = paddr_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pstrb_d       = pstrb_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          paddr_d     = cmd_addr;
          pwrite_d    = cmd_write;
          pwdata_d    = cmd_write ? cmd_wdata : '0;
          pstrb_d     = cmd_write ? cmd_strb : '0;
          psel_d      = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // PREADY is checked first so a completion on the limit cycle is not aborted.
        if (PREADY) begin
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_slverr_d  = PSLVERR;
          rsp_timeout_d = 1'b0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else if (to_limit) begin
          rsp_rdata_d   = '0;
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b1;
      paddr_q       <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pstrb_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      paddr_q       <= paddr_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pstrb_q       <= pstrb_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign PADDR       = paddr_q;
  assign PSELx       = psel_q;
  assign PENABLE     = penable_q;
  assign PSTRB       = pstrb_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
